// File: rtl/tree_stim_checker.sv
// -----------------------------------------------------------------------------
// tree_stim_checker
//
// Stimulus driver and response checker for the registered adder-tree designs.
// A 16-bit Fibonacci LFSR drives the four 1-bit tree operands. The tree result
// is compared each cycle against an XOR of taps taken from a short history of
// the operands this block drove itself.
//
// Parameters
//   SEED    : LFSR seed (0 is replaced by 16'h0001)
//   NCYCLES : number of stimulus cycles, 1..65535
//   MAXDLY  : history depth in cycles, 1..15
//   TAPS    : bit 4*k+i selects operand i (0=a..3=d) driven k cycles earlier
//
// Ports
//   i_clk         : clock, all logic on the rising edge
//   i_reset       : synchronous active-high reset
//   i_start       : one-cycle pulse that starts (or restarts) a run
//   i_sum         : tree output under test
//   o_a..o_d      : registered stimulus
//   o_busy        : run or drain in progress
//   o_done        : run complete, results valid
//   o_pass        : no mismatches seen (valid with o_done)
//   o_err_count   : saturating mismatch count
//   o_first_err   : run-cycle index of the first mismatch, 16'hFFFF if none
// -----------------------------------------------------------------------------
module tree_stim_checker #(
    parameter logic [15:0]          SEED    = 16'hACE1,
    parameter int unsigned          NCYCLES = 1000,
    parameter int unsigned          MAXDLY  = 8,
    parameter logic [4*MAXDLY-1:0]  TAPS    = 32'h000F_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_sum,
    output logic        o_a,
    output logic        o_b,
    output logic        o_c,
    output logic        o_d,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [15:0] o_err_count,
    output logic [15:0] o_first_err
);

    localparam int unsigned L_HW      = 4 * MAXDLY;
    localparam logic [15:0] L_SEED    = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] L_NC_LAST = 16'(NCYCLES - 1);
    localparam logic [15:0] L_MD_LAST = 16'(MAXDLY - 1);
    localparam logic [15:0] L_MAXDLY  = 16'(MAXDLY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One step of x^16+x^14+x^13+x^11+1, shifting left.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_lfsr;
    logic [15:0]       r_cnt;
    logic [15:0]       r_t;
    logic [15:0]       r_err;
    logic [15:0]       r_first;
    // Operand history, nibble k = {d,c,b,a} driven k cycles ago; nibble 0
    // is what is on the output pins right now.
    logic [L_HW-1:0]   r_hist;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic              w_enter_run;
    logic [3:0]        w_new;
    logic              w_expected;
    logic              w_mismatch;
    logic [15:0]       w_err_next;

    // Next-state logic for the run sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_RUN;
                else         w_state_next = S_IDLE;
            end
            S_RUN: begin
                if (r_cnt == L_NC_LAST) w_state_next = S_DRAIN;
                else                    w_state_next = S_RUN;
            end
            S_DRAIN: begin
                if (r_cnt == L_MD_LAST) w_state_next = S_DONE;
                else                    w_state_next = S_DRAIN;
            end
            S_DONE: begin
                if (i_start) w_state_next = S_RUN;
                else         w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Start of a run from IDLE or DONE; the counters are reinitialised here.
    always_comb begin
        w_enter_run = 1'b0;
        if ((w_state_next == S_RUN) && (r_state != S_RUN)) w_enter_run = 1'b1;
        else                                               w_enter_run = 1'b0;
    end

    // Nibble shifted into the history: live LFSR bits in RUN, zeros in DRAIN.
    always_comb begin
        w_new = 4'h0;
        if (r_state == S_RUN) w_new = r_lfsr[3:0];
        else                  w_new = 4'h0;
    end

    // Expected tree output and mismatch accounting. r_busy marks cycles whose
    // operands are on the pins, so r_t indexes the stimulus currently driven.
    always_comb begin
        w_expected = ^(r_hist & TAPS);
        w_mismatch = r_busy && (r_t >= L_MAXDLY) && (i_sum != w_expected);
        w_err_next = r_err;
        if (w_mismatch && (r_err != 16'hFFFF)) w_err_next = r_err + 16'd1;
        else                                   w_err_next = r_err;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Datapath: LFSR, history, counters and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_enter_run) begin
            r_lfsr  <= L_SEED;
            r_cnt   <= 16'h0000;
            r_t     <= 16'h0000;
            r_err   <= 16'h0000;
            r_first <= 16'hFFFF;
            r_hist  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_busy <= (r_state == S_RUN) || (r_state == S_DRAIN);
            r_done <= (r_state == S_DONE);
            r_pass <= (r_state == S_DONE) && (w_err_next == 16'h0000);
            r_err  <= w_err_next;
            if (w_mismatch && (r_err == 16'h0000)) r_first <= r_t;
            if (r_busy && (r_t != 16'hFFFF)) r_t <= r_t + 16'd1;
            case (r_state)
                S_RUN: begin
                    r_lfsr <= lfsr_step(r_lfsr);
                    r_hist <= (r_hist << 4) | L_HW'(w_new);
                    if (r_cnt == L_NC_LAST) r_cnt <= 16'h0000;
                    else                    r_cnt <= r_cnt + 16'd1;
                end
                S_DRAIN: begin
                    r_hist <= (r_hist << 4) | L_HW'(w_new);
                    r_cnt  <= r_cnt + 16'd1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign o_a         = r_hist[0];
    assign o_b         = r_hist[1];
    assign o_c         = r_hist[2];
    assign o_d         = r_hist[3];
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_count = r_err;
    assign o_first_err = r_first;

endmodule
